// File: rtl/serial_csel_adder.sv
// serial_csel_adder
//   Bit-serial adder that consumes the operands two bits per clock. Each
//   2-bit slice is evaluated twice in parallel (carry-in 0 and carry-in 1)
//   and the stored running carry picks the correct result (carry-select).
//   A result appears WIDTH/2 edges after the operands are accepted.
//
// Ports
//   clk        : clock, all state updates on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : operand set presented on a/b/cin
//   in_ready   : block accepts operands this cycle (IDLE only)
//   a, b       : WIDTH-bit addends
//   cin        : carry into bit 0
//   out_valid  : result held on sum/cout/ovf (DONE only)
//   out_ready  : consumer takes the result
//   sum        : low WIDTH bits of a+b+cin
//   cout       : carry out of bit WIDTH-1
//   ovf        : two's-complement overflow
//   busy       : operation in progress or result waiting (RUN or DONE)
module serial_csel_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int NSL = WIDTH / 2;
  localparam int KW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [KW-1:0] LAST_K = KW'(NSL - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_carry;
  logic [KW-1:0]    r_k;

  logic [1:0]       w_a_sl;
  logic [1:0]       w_b_sl;
  logic [3:0]       w_res0;
  logic [3:0]       w_res1;
  logic [3:0]       w_sel;

  // Two-bit ripple chain; returns {carry out, carry into bit 1, s1, s0}.
  // The middle carry is needed because on the top slice it is the carry
  // into the sign bit, which the overflow rule depends on.
  function automatic logic [3:0] slice_add(input logic [1:0] x,
                                           input logic [1:0] y,
                                           input logic       c);
    logic s0, s1, c1, c2;
    s0 = x[0] ^ y[0] ^ c;
    c1 = (x[0] & y[0]) | (x[0] & c) | (y[0] & c);
    s1 = x[1] ^ y[1] ^ c1;
    c2 = (x[1] & y[1]) | (x[1] & c1) | (y[1] & c1);
    return {c2, c1, s1, s0};
  endfunction

  assign w_a_sl = r_a[{r_k, 1'b0} +: 2];
  assign w_b_sl = r_b[{r_k, 1'b0} +: 2];
  assign w_res0 = slice_add(w_a_sl, w_b_sl, 1'b0);
  assign w_res1 = slice_add(w_a_sl, w_b_sl, 1'b1);
  assign w_sel  = r_carry ? w_res1 : w_res0;

  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);
  assign busy      = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (r_k == LAST_K) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operand capture, per-slice sum/carry update and final flag load.
  // Results are left untouched in IDLE so a taken result stays visible
  // until the next acceptance clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_carry <= 1'b0;
      r_k     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_k     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
          end
        end
        ST_RUN: begin
          r_sum[{r_k, 1'b0} +: 2] <= w_sel[1:0];
          r_carry                 <= w_sel[3];
          if (r_k == LAST_K) begin
            // k is left at its last value rather than wrapping.
            r_cout <= w_sel[3];
            r_ovf  <= w_sel[3] ^ w_sel[2];
          end else begin
            r_k <= r_k + KW'(1);
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_csel_adder.sv
module tb_serial_csel_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       cin = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       cout;
  logic       ovf;
  logic       busy;

  serial_csel_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] s;
    logic       co;
    logic       ov;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  bit   rnd_stall = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: compares the held result every DONE cycle, pops on handshake.
  initial begin
    logic prev_ov;
    prev_ov = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (!rst_n) begin
        prev_ov = 1'b0;
      end else begin
        chk("ready_vs_busy", {31'd0, in_ready}, {31'd0, ~busy});
        if (out_valid) begin
          if (q.size() == 0) begin
            chk("unexpected_out_valid", 32'd1, 32'd0);
          end else begin
            if (!prev_ov) chk("latency", cyc - q[0].acc, 32'd4);
            chk("sum",  {24'd0, sum},  {24'd0, q[0].s});
            chk("cout", {31'd0, cout}, {31'd0, q[0].co});
            chk("ovf",  {31'd0, ovf},  {31'd0, q[0].ov});
            if (out_ready) void'(q.pop_front());
          end
        end
        prev_ov = out_valid;
      end
    end
  end

  task automatic send(input logic [7:0] xa, input logic [7:0] xb, input logic xc,
                      input logic [7:0] es, input logic eco, input logic eov);
    int n;
    exp_t e;
    n = 0;
    @(negedge clk);
    a = xa; b = xb; cin = xc; in_valid = 1'b1;
    #2;
    while (!in_ready && n < 60) begin
      out_ready = rnd_stall ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      #2;
      n++;
    end
    if (!in_ready) begin
      chk("accept_timeout", 32'd0, 32'd1);
    end else begin
      @(posedge clk);
      #1;
      e.s = es; e.co = eco; e.ov = eov; e.acc = cyc;
      q.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [7:0] xa, input logic [7:0] xb, input logic xc);
    logic [8:0] r;
    logic       v;
    r = {1'b0, xa} + {1'b0, xb} + {8'd0, xc};
    v = (xa[7] == xb[7]) && (r[7] != xa[7]);
    send(xa, xb, xc, r[7:0], r[8], v);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || !in_ready) && n < 100) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("drain", q.size(), 32'd0);
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, "_sum"},       {24'd0, sum},       32'd0);
    chk({tag, "_cout"},      {31'd0, cout},      32'd0);
    chk({tag, "_ovf"},       {31'd0, ovf},       32'd0);
    chk({tag, "_in_ready"},  {31'd0, in_ready},  32'd1);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_busy"},      {31'd0, busy},      32'd0);
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clk);
    #2;
    chk_reset_outs("por");
    @(negedge clk);
    rst_n = 1'b1;

    // Basic add, then result must stay visible in IDLE.
    send(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
    wait_idle();
    chk("idle_hold_sum", {24'd0, sum}, 32'h4B);

    // Reset while idle clears the held result.
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk_reset_outs("idle_rst");
    @(negedge clk);
    rst_n = 1'b1;

    send(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    send(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    send(8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0);
    send(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    wait_idle();

    // Backpressure: hold DONE for 5 cycles while new operands are offered.
    out_ready = 1'b0;
    send(8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0, 1'b0);
    n = 0;
    #2;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    chk("bp_reach_done", {31'd0, out_valid}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      a = 8'h11; b = 8'h22; cin = 1'b1; in_valid = 1'b1;
      #2;
      chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
      chk("bp_out_valid", {31'd0, out_valid}, 32'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    #2;
    chk("bp_idle_ready", {31'd0, in_ready}, 32'd1);
    chk("bp_idle_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_sum_kept", {24'd0, sum}, 32'h4B);
    wait_idle();

    // Abort mid-operation: no result may ever be presented.
    send(8'hAA, 8'h55, 1'b0, 8'hFF, 1'b0, 1'b0);
    void'(q.pop_back());
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    chk_reset_outs("mid_rst");
    @(negedge clk);
    rst_n = 1'b1;
    send(8'h01, 8'h02, 1'b1, 8'h04, 1'b0, 1'b0);
    wait_idle();

    // Randomised operands with random consumer stalls.
    rnd_stall = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      send_model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)));
    end
    rnd_stall = 1'b0;
    out_ready = 1'b1;
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
